sort_result_streamer: RTL and testbench
=======================================

SORT_RESULT_STREAMER -- requirements
Module: sort_result_streamer

Interface
REQ-001 The module SHALL have parameter SIZE_ADDR, default 4, giving the RAM address width; depth is 2**SIZE_ADDR.
REQ-002 The module SHALL have parameter SIZE_DATA, default 8, giving the element width.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port i_start, input, 1 bit: start-stream pulse, driven by the sorter's o_done.
REQ-006 The module SHALL have port i_num_elems, input, SIZE_ADDR bits: element count; 0 encodes 2**SIZE_ADDR.
REQ-007 The module SHALL have port o_rd_en, output, 1 bit: RAM read strobe.
REQ-008 The module SHALL have port o_rd_addr, output, SIZE_ADDR bits: RAM read address.
REQ-009 The module SHALL have port i_rd_data, input, SIZE_DATA bits: RAM read data, valid exactly one cycle after o_rd_en.
REQ-010 The module SHALL have port o_valid, output, 1 bit: stream data valid.
REQ-011 The module SHALL have port o_data, output, SIZE_DATA bits: stream data.
REQ-012 The module SHALL have port o_last, output, 1 bit: marks the final element, qualified by o_valid.
REQ-013 The module SHALL have port i_ready, input, 1 bit: downstream accepts; a transfer occurs when o_valid && i_ready.
REQ-014 The module SHALL have port o_busy, output, 1 bit: a stream is in progress.
REQ-015 The module SHALL have port o_done, output, 1 bit: one-cycle pulse after the last transfer.
REQ-016 The module SHALL have port o_order_err, output, 1 bit: sticky ordering-violation flag (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN, FINISH.
REQ-018 In IDLE, i_start=1 SHALL latch i_num_elems, clear the read and beat counters, and enter READ.
REQ-019 In READ, o_rd_en SHALL assert only if buffer occupancy plus in-flight reads is below 2; o_rd_addr SHALL run 0,1,...,N-1 and never exceed N-1.
REQ-020 After the N-th read is issued, the FSM SHALL enter DRAIN, and SHALL stay there until the transfer carrying o_last completes.
REQ-021 DRAIN SHALL then go to FINISH; FINISH SHALL pulse o_done for exactly one cycle and return to IDLE.
REQ-022 Read data SHALL enter a 2-entry FIFO; o_valid SHALL equal FIFO non-empty and o_data SHALL be the FIFO head.
REQ-023 o_data and o_last SHALL remain stable while o_valid=1 and i_ready=0.
REQ-024 With i_ready held high, the first o_valid SHALL occur 3 cycles after the i_start cycle, followed by one beat per cycle with no bubbles.
REQ-025 o_last SHALL be high only on beat N, where N = i_num_elems, or 2**SIZE_ADDR when i_num_elems=0.
REQ-026 o_busy SHALL be high in READ, DRAIN and FINISH.
REQ-027 i_start while o_busy=1 SHALL be ignored.
REQ-028 FIFO push and pop in the same cycle SHALL leave occupancy unchanged; no element SHALL be lost or duplicated.

Reset
REQ-029 Asserting i_rst SHALL immediately force state IDLE, flush the FIFO and clear all counters.
REQ-030 During reset, o_rd_en, o_rd_addr, o_valid, o_data, o_last, o_busy, o_done and o_order_err SHALL all be 0.
REQ-031 Reset asserted mid-stream SHALL abandon the stream; the next i_start after release SHALL restart from address 0.

Configuration
REQ-032 Macro STREAM_ORDER_CHECK_EN defined: o_order_err SHALL set when a transferred element is less than the previously transferred element (unsigned compare); it SHALL stay set until the next accepted i_start or reset.
REQ-033 Macro STREAM_ORDER_CHECK_EN undefined: the comparator and previous-value register SHALL be absent and o_order_err SHALL be tied to 0.

Structure
REQ-034 Package sort_pkg SHALL hold the default SIZE_ADDR/SIZE_DATA constants and the streamer state enum typedef.
REQ-035 The FIFO SHALL be a separate sub-module, sort_stream_fifo (2 entries, push/pop/full/empty, parameterised by width).

Verification
REQ-036 Scenario: RAM[0..4]=03,07,0A,10,2F; N=5; i_ready=1 -> o_rd_addr 0..4, beats 03,07,0A,10,2F, o_last on 2F, o_done one cycle after it.
REQ-037 Scenario: i_num_elems=0 with a 16-entry ramp 00..0F -> 16 beats, o_last on 0F, o_rd_addr never wraps past 15.
REQ-038 Scenario: N=4; i_ready toggling 1,0,1,0 -> 4 beats in order, o_data stable while stalled, at most 2 reads outstanding.
REQ-039 Scenario: i_start re-pulsed at beat 2 of an N=5 stream -> ignored; exactly 5 beats and one o_done.
REQ-040 Scenario: i_rst pulsed after 3 beats of N=8 -> all outputs 0 at once; a fresh i_start yields 8 beats starting from RAM[0].
REQ-041 Scenario (STREAM_ORDER_CHECK_EN defined): RAM=05,03 with N=2 -> o_order_err rises after beat 2 and stays 1 until the next i_start.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and state type for the sort result streamer
// Purpose: default RAM address/data widths and the streamer FSM state enum.
// Ports: none (package).
package sort_pkg;

    localparam int DEFAULT_SIZE_ADDR = 4;
    localparam int DEFAULT_SIZE_DATA = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } stream_state_t;

endpackage

// File: rtl/sort_stream_fifo.sv
// rtl/sort_stream_fifo.sv - two-entry FIFO between RAM read data and the output stream
// Purpose: buffers up to two read-data words; head word is always visible on o_data.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset (flushes contents)
//   i_push, i_data   write strobe and word (ignored when full)
//   i_pop            remove head word (ignored when empty)
//   o_data           head word
//   o_full, o_empty  occupancy flags
module sort_stream_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop keeps the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sort_result_streamer.sv
// rtl/sort_result_streamer.sv - streams N sorted words out of a RAM as a valid/ready stream
// Purpose: on i_start reads RAM addresses 0..N-1 and emits them in order with o_last on
//   the final word, then pulses o_done. Optional macro STREAM_ORDER_CHECK_EN adds a sticky
//   flag that sets when a transferred word is smaller than the one before it.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start, i_num_elems   start pulse and element count (0 means 2**SIZE_ADDR)
//   o_rd_en, o_rd_addr     RAM read strobe and address
//   i_rd_data              RAM data, valid one cycle after o_rd_en
//   o_valid, o_data,       output stream; transfer when o_valid && i_ready
//   o_last, i_ready
//   o_busy, o_done         stream in progress, one-cycle completion pulse
//   o_order_err            sticky ordering-violation flag (0 when the check is not built)
module sort_result_streamer
    import sort_pkg::*;
#(
    parameter int SIZE_ADDR = DEFAULT_SIZE_ADDR,
    parameter int SIZE_DATA = DEFAULT_SIZE_DATA
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_num_elems,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_rd_addr,
    input  logic [SIZE_DATA-1:0] i_rd_data,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_last,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_order_err
);

    localparam logic [SIZE_ADDR-1:0] ADDR_ONE = {{(SIZE_ADDR-1){1'b0}}, 1'b1};

    stream_state_t        r_state;
    stream_state_t        w_next;
    logic [SIZE_ADDR-1:0] r_last_idx;
    logic [SIZE_ADDR-1:0] r_rd_addr;
    logic [SIZE_ADDR-1:0] r_beat_cnt;
    logic                 r_inflight;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [SIZE_DATA-1:0] w_fifo_data;
    logic                 w_pop;
    logic [1:0]           w_occ;
    logic [1:0]           w_occ_after_pop;
    logic [1:0]           w_outstanding;
    logic                 w_rd_en;
    logic                 w_read_last;
    logic                 w_last;
    logic                 w_accept_start;

    sort_stream_fifo #(
        .WIDTH (SIZE_DATA)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_data  (i_rd_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_pop = !w_fifo_empty && i_ready;
    assign w_occ = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);

    // A word leaving this cycle frees its slot, which lets reads run back to back
    // with a ready sink while never holding more than two words in total.
    assign w_occ_after_pop = w_occ - {1'b0, w_pop};
    assign w_outstanding   = w_occ_after_pop + {1'b0, r_inflight};
    assign w_rd_en         = (r_state == ST_READ) && (w_outstanding < 2'd2);
    assign w_read_last     = w_rd_en && (r_rd_addr == r_last_idx);

    // Count 0 wraps to all-ones as the last index, giving a full 2**SIZE_ADDR stream.
    assign w_last          = !w_fifo_empty && (r_beat_cnt == r_last_idx);
    assign w_accept_start  = (r_state == ST_IDLE) && i_start;

    assign o_rd_en   = w_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_valid   = !w_fifo_empty;
    assign o_data    = w_fifo_data;
    assign o_last    = w_last;

    always_comb begin
        w_next = r_state;
        o_busy = 1'b1;
        o_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                if (w_read_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_last) begin
                    w_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_last_idx <= '0;
            r_rd_addr  <= '0;
            r_beat_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
            if (w_accept_start) begin
                r_last_idx <= i_num_elems - ADDR_ONE;
                r_rd_addr  <= '0;
                r_beat_cnt <= '0;
            end else begin
                // Address parks on N-1 after the final read instead of running past it.
                if (w_rd_en && !w_read_last) begin
                    r_rd_addr <= r_rd_addr + ADDR_ONE;
                end
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + ADDR_ONE;
                end
            end
        end
    end

`ifdef STREAM_ORDER_CHECK_EN
    logic [SIZE_DATA-1:0] r_prev;
    logic                 r_have_prev;
    logic                 r_order_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_order_err <= 1'b0;
        end else if (w_accept_start) begin
            r_have_prev <= 1'b0;
            r_order_err <= 1'b0;
        end else if (w_pop) begin
            r_prev      <= w_fifo_data;
            r_have_prev <= 1'b1;
            if (r_have_prev && (w_fifo_data < r_prev)) begin
                r_order_err <= 1'b1;
            end
        end
    end

    assign o_order_err = r_order_err;
`else
    assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// tb/tb_sort_result_streamer.sv - scoreboard bench for sort_result_streamer
module tb_sort_result_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] num = 4'd0;
    logic       ready = 1'b1;
    logic       tog = 1'b0;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'd0;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       busy;
    logic       done;
    logic       order_err;

    logic [7:0] ram [16];
    logic [7:0] exp_data_q [$];
    logic       exp_last_q [$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int reads_issued = 0;
    int max_out = 0;
    int exp_addr = 0;
    int last_fire_cyc = -10;
    logic       stall_pending = 1'b0;
    logic [7:0] stall_data = 8'd0;
    logic       stall_last = 1'b0;

    sort_result_streamer #(.SIZE_ADDR(4), .SIZE_DATA(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_num_elems (num),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_valid     (valid),
        .o_data      (data),
        .o_last      (last),
        .i_ready     (ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_order_err (order_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid", {31'd0, valid}, 32'd1);
                check("stall_data", {24'd0, data}, {24'd0, stall_data});
                check("stall_last", {31'd0, last}, {31'd0, stall_last});
            end
            stall_pending = valid && !ready;
            stall_data = data;
            stall_last = last;
            if (rd_en) begin
                check("rd_addr", {28'd0, rd_addr}, exp_addr);
                exp_addr++;
                reads_issued++;
            end
            if (valid && ready) begin
                if (exp_data_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", data);
                end else begin
                    check("beat_data", {24'd0, data}, {24'd0, exp_data_q.pop_front()});
                    check("beat_last", {31'd0, last}, {31'd0, exp_last_q.pop_front()});
                end
                beat_cnt++;
                if (last) last_fire_cyc = cyc;
            end
            if (reads_issued - beat_cnt > max_out) max_out = reads_issued - beat_cnt;
            if (done) begin
                done_cnt++;
                check("done_after_last", cyc - last_fire_cyc, 32'd1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) ready = ~ready;
            else ready = 1'b1;
        end
    end

    task automatic prep(input int n);
        exp_addr = 0;
        beat_cnt = 0;
        reads_issued = 0;
        max_out = 0;
        for (int i = 0; i < n; i++) begin
            exp_data_q.push_back(ram[i]);
            exp_last_q.push_back(i == n - 1);
        end
    endtask

    task automatic pulse_start(input logic [3:0] ne);
        @(posedge clk);
        #1;
        num = ne;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string nm);
        int t;
        t = 0;
        while (done_cnt == base && t < 300) begin
            @(posedge clk);
            t++;
        end
        check({nm, "_done_seen"}, {31'd0, done_cnt > base}, 32'd1);
        repeat (6) @(posedge clk);
        check({nm, "_done_count"}, done_cnt - base, 32'd1);
        check({nm, "_queue_empty"}, exp_data_q.size(), 32'd0);
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (beat_cnt < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("beats_reached", {31'd0, beat_cnt >= n}, 32'd1);
    endtask

    initial begin
        int base;
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] v5 [5];
        v5[0] = 8'h03; v5[1] = 8'h07; v5[2] = 8'h0A; v5[3] = 8'h10; v5[4] = 8'h2F;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {rd_en, rd_addr, valid, data, last, busy, done, order_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // N=5, ready high: latency, addresses, beats, last and done.
        for (int i = 0; i < 5; i++) ram[i] = v5[i];
        prep(5);
        base = done_cnt;
        pulse_start(4'd5);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("no_valid_at_2", {31'd0, valid}, 32'd0);
        @(posedge clk);
        #1;
        check("valid_at_3", {31'd0, valid}, 32'd1);
        check("first_data", {24'd0, data}, 32'h03);
        wait_done(base, "n5");
        check("busy_idle", {31'd0, busy}, 32'd0);

        // N=0 means 16: ramp 00..0F.
        for (int i = 0; i < 16; i++) ram[i] = i[7:0];
        prep(16);
        base = done_cnt;
        pulse_start(4'd0);
        wait_done(base, "n16");
        check("n16_reads", reads_issued, 32'd16);

        // N=4 with ready toggling.
        for (int i = 0; i < 4; i++) ram[i] = 8'h40 + i[7:0];
        prep(4);
        base = done_cnt;
        tog = 1'b1;
        pulse_start(4'd4);
        wait_done(base, "n4_stall");
        tog = 1'b0;
        check("max_outstanding_le2", {31'd0, max_out <= 2}, 32'd1);

        // Re-pulsed start during an N=5 stream is ignored.
        for (int i = 0; i < 5; i++) ram[i] = v5[i];
        prep(5);
        base = done_cnt;
        pulse_start(4'd5);
        wait_beats(2);
        pulse_start(4'd5);
        wait_done(base, "restart_ignored");

        // Reset after 3 beats of N=8, then a fresh stream.
        for (int i = 0; i < 8; i++) ram[i] = 8'h11 * (i[7:0] + 8'd1);
        prep(8);
        base = done_cnt;
        pulse_start(4'd8);
        wait_beats(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {rd_en, rd_addr, valid, data, last, busy, done, order_err}, 32'd0);
        exp_data_q.delete();
        exp_last_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        prep(8);
        base = done_cnt;
        pulse_start(4'd8);
        wait_done(base, "after_rst");

        // Descending pair: order flag behaviour.
        ram[0] = 8'h05;
        ram[1] = 8'h03;
        prep(2);
        base = done_cnt;
        pulse_start(4'd2);
        wait_done(base, "order");
`ifdef STREAM_ORDER_CHECK_EN
        check("order_err_set", {31'd0, order_err}, 32'd1);
`else
        check("order_err_tied", {31'd0, order_err}, 32'd0);
`endif
        ram[0] = 8'h01;
        ram[1] = 8'h02;
        prep(2);
        base = done_cnt;
        pulse_start(4'd2);
        check("order_err_cleared", {31'd0, order_err}, 32'd0);
        wait_done(base, "ordered");
        check("order_err_clean", {31'd0, order_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
